// File: rtl/matmul_2x2_seq_ctrl.sv
// matmul_2x2_seq_ctrl
//   Computes c = A*b (2x2 matrix by 2x1 vector, floating point). It uses one
//   shared external multiplier and one shared external add_sub, which are
//   sequenced over four compute cycles.
//
//   Sequence: P11 (a11*b1 -> p_reg), C1 (p_reg + a12*b2 -> c1),
//             P21 (a21*b1 -> p_reg), C2 (p_reg + a22*b2 -> c2), DONE.
//
// Parameters
//   exp_width  : exponent field width
//   mant_width : mantissa width incl. hidden bit (word W = exp_width + mant_width)
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid / in_ready     : operand handshake (ready only when idle)
//   a11,a12,a21,a22,b1,b2   : operands, latched on accept
//   round_mode              : rounding mode, latched on accept
//   out_valid / out_ready   : result handshake; c1/c2 held while stalled
//   c1, c2                  : results
//   mul_a, mul_b, mul_rm    : shared multiplier operand bus (0 when unused)
//   mul_out, mul_exc        : multiplier result / exceptions (combinational)
//   add_x, add_y, add_op,
//   add_rm                  : shared add_sub operand bus (add_op always 0)
//   add_out, add_exc        : add_sub result / exceptions (combinational)
//   exceptions              : sticky exception OR for the current operation
//
// Optional feature (macro MATMUL_SEQ_EXC_EN)
//   Defined  : exceptions is cleared on accept. It accumulates mul_exc in all
//              four compute states and add_exc in C1/C2.
//   Undefined: exceptions is tied to zero, and mul_exc/add_exc are unused.
module matmul_2x2_seq_ctrl #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [exp_width+mant_width-1:0] a11,
  input  logic [exp_width+mant_width-1:0] a12,
  input  logic [exp_width+mant_width-1:0] a21,
  input  logic [exp_width+mant_width-1:0] a22,
  input  logic [exp_width+mant_width-1:0] b1,
  input  logic [exp_width+mant_width-1:0] b2,
  input  logic [2:0]                      round_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [exp_width+mant_width-1:0] c1,
  output logic [exp_width+mant_width-1:0] c2,
  output logic [exp_width+mant_width-1:0] mul_a,
  output logic [exp_width+mant_width-1:0] mul_b,
  output logic [2:0]                      mul_rm,
  input  logic [exp_width+mant_width-1:0] mul_out,
  input  logic [4:0]                      mul_exc,
  output logic [exp_width+mant_width-1:0] add_x,
  output logic [exp_width+mant_width-1:0] add_y,
  output logic                            add_op,
  output logic [2:0]                      add_rm,
  input  logic [exp_width+mant_width-1:0] add_out,
  input  logic [4:0]                      add_exc,
  output logic [4:0]                      exceptions
);

  localparam int W = exp_width + mant_width;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_P11 = 3'd1,
    S_C1  = 3'd2,
    S_P21 = 3'd3,
    S_C2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, next_state;

  logic [W-1:0] a11_r, a12_r, a21_r, a22_r, b1_r, b2_r;
  logic [W-1:0] p_reg;
  logic [2:0]   rm_r;
  logic         accept;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next state and datapath steering
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    add_x      = '0;
    add_y      = '0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_P11;
      end
      S_P11: begin
        mul_a      = a11_r;
        mul_b      = b1_r;
        next_state = S_C1;
      end
      S_C1: begin
        // The second product feeds the adder in the same cycle.
        mul_a      = a12_r;
        mul_b      = b2_r;
        add_x      = p_reg;
        add_y      = mul_out;
        next_state = S_P21;
      end
      S_P21: begin
        mul_a      = a21_r;
        mul_b      = b1_r;
        next_state = S_C2;
      end
      S_C2: begin
        mul_a      = a22_r;
        mul_b      = b2_r;
        add_x      = p_reg;
        add_y      = mul_out;
        next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign mul_rm = rm_r;
  assign add_rm = rm_r;
  assign add_op = 1'b0;

  // Operand latch, partial product and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a11_r <= '0;
      a12_r <= '0;
      a21_r <= '0;
      a22_r <= '0;
      b1_r  <= '0;
      b2_r  <= '0;
      rm_r  <= '0;
      p_reg <= '0;
      c1    <= '0;
      c2    <= '0;
    end else begin
      if (accept) begin
        a11_r <= a11;
        a12_r <= a12;
        a21_r <= a21;
        a22_r <= a22;
        b1_r  <= b1;
        b2_r  <= b2;
        rm_r  <= round_mode;
      end
      unique case (state)
        S_P11:   p_reg <= mul_out;
        S_C1:    c1    <= add_out;
        S_P21:   p_reg <= mul_out;
        S_C2:    c2    <= add_out;
        default: ;
      endcase
    end
  end

`ifdef MATMUL_SEQ_EXC_EN
  logic [4:0] exc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_r <= '0;
    end else if (accept) begin
      exc_r <= '0;
    end else begin
      unique case (state)
        S_P11, S_P21: exc_r <= exc_r | mul_exc;
        S_C1,  S_C2:  exc_r <= exc_r | mul_exc | add_exc;
        default:      ;
      endcase
    end
  end

  assign exceptions = exc_r;
`else
  logic unused_exc;
  assign unused_exc = ^{mul_exc, add_exc};
  assign exceptions = '0;
`endif

endmodule

// File: tb/tb_matmul_2x2_seq_ctrl.sv
// Testbench for matmul_2x2_seq_ctrl.
//   Stands in for the shared FPU units with a real-arithmetic stub. Each
//   cycle it checks the DUT against a transaction-level model: the model
//   knows the compute-step number since accept, the expected bus operands
//   for that step, and the expected results. Directed vectors also carry
//   hand-computed literal results.
module tb_matmul_2x2_seq_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a11, a12, a21, a22, b1, b2;
  logic [2:0]   round_mode;
  logic         out_valid, out_ready;
  logic [W-1:0] c1, c2;
  logic [W-1:0] mul_a, mul_b, mul_out;
  logic [2:0]   mul_rm, add_rm;
  logic [4:0]   mul_exc, add_exc, exceptions;
  logic [W-1:0] add_x, add_y, add_out;
  logic         add_op;

  int vec_count  = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  matmul_2x2_seq_ctrl #(.exp_width(8), .mant_width(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22), .b1(b1), .b2(b2),
    .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .c1(c1), .c2(c2),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rm(mul_rm),
    .mul_out(mul_out), .mul_exc(mul_exc),
    .add_x(add_x), .add_y(add_y), .add_op(add_op), .add_rm(add_rm),
    .add_out(add_out), .add_exc(add_exc),
    .exceptions(exceptions)
  );

  // ---------------- single-precision helpers (normals, zero, inf) ----------
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    int e;
    e = int'(x[30:23]);
    if (e == 0)   return 0.0;
    if (e == 255) return x[31] ? -1.0e300 : 1.0e300;
    d = {x[31], 11'(e - 127 + 1023), x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0)   return {d[63], 31'h0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [31:0] fm(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction

  function automatic logic [31:0] fa(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  // Overflow flag (bit 2) whenever a result saturates to infinity.
  function automatic logic [4:0] fx(input logic [31:0] r);
    return (r[30:23] == 8'hFF) ? 5'b00100 : 5'b00000;
  endfunction

  // ---------------- FPU stub ------------------------------------------------
  always_comb begin
    mul_out = fm(mul_a, mul_b);
    mul_exc = fx(mul_out);
    add_out = fa(add_x, add_y);
    add_exc = fx(add_out);
  end

  // ---------------- checking ------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: step = -1 idle, 1..4 compute step, 5 result offered.
  int          step;
  logic [31:0] m_a11, m_a12, m_a21, m_a22, m_b1, m_b2;
  logic [2:0]  m_rm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step = -1;
      m_rm = 3'd0;
    end else if (step == -1) begin
      if (in_valid) begin
        m_a11 = a11; m_a12 = a12; m_a21 = a21; m_a22 = a22;
        m_b1  = b1;  m_b2  = b2;  m_rm  = round_mode;
        step  = 1;
      end
    end else if (step < 5) begin
      step = step + 1;
    end else if (out_ready) begin
      step = -1;
    end
  end

  logic [31:0] e_ma, e_mb, e_ax, e_ay, e_c1, e_c2;
  logic [4:0]  e_exc;

  always @(negedge clk) begin
    if (rst_n) begin
      e_ma = 0; e_mb = 0; e_ax = 0; e_ay = 0;
      case (step)
        1: begin e_ma = m_a11; e_mb = m_b1; end
        2: begin e_ma = m_a12; e_mb = m_b2; e_ax = fm(m_a11, m_b1); e_ay = fm(m_a12, m_b2); end
        3: begin e_ma = m_a21; e_mb = m_b1; end
        4: begin e_ma = m_a22; e_mb = m_b2; e_ax = fm(m_a21, m_b1); e_ay = fm(m_a22, m_b2); end
        default: ;
      endcase
      chk("in_ready",  32'(in_ready),  32'(step == -1));
      chk("out_valid", 32'(out_valid), 32'(step == 5));
      chk("mul_a", mul_a, e_ma);
      chk("mul_b", mul_b, e_mb);
      chk("add_x", add_x, e_ax);
      chk("add_y", add_y, e_ay);
      chk("add_op", 32'(add_op), 32'd0);
      chk("mul_rm", 32'(mul_rm), 32'(m_rm));
      chk("add_rm", 32'(add_rm), 32'(m_rm));
      if (step == 5) begin
        e_c1 = fa(fm(m_a11, m_b1), fm(m_a12, m_b2));
        e_c2 = fa(fm(m_a21, m_b1), fm(m_a22, m_b2));
`ifdef MATMUL_SEQ_EXC_EN
        e_exc = fx(fm(m_a11, m_b1)) | fx(fm(m_a12, m_b2)) | fx(fm(m_a21, m_b1))
              | fx(fm(m_a22, m_b2)) | fx(e_c1) | fx(e_c2);
`else
        e_exc = 5'd0;
`endif
        chk("c1", c1, e_c1);
        chk("c2", c2, e_c2);
        chk("exceptions", 32'(exceptions), 32'(e_exc));
      end
`ifndef MATMUL_SEQ_EXC_EN
      chk("exceptions_tied", 32'(exceptions), 32'd0);
`endif
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic set_ops(input logic [31:0] x11, x12, x21, x22, y1, y2, input logic [2:0] rm);
    a11 = x11; a12 = x12; a21 = x21; a22 = x22; b1 = y1; b2 = y2; round_mode = rm;
  endtask

  // Present operands until accepted (bounded).
  task automatic send(input logic [31:0] x11, x12, x21, x22, y1, y2, input logic [2:0] rm);
    bit ok = 0;
    set_ops(x11, x12, x21, x22, y1, y2, rm);
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #2;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready never seen");
    end
  endtask

  // Wait for out_valid, returning at a negedge with it high (bounded).
  task automatic wait_done(input string nm, input logic [31:0] x1, x2);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL %s_timeout: out_valid never seen", nm);
    end else begin
      chk({nm, "_c1_lit"}, c1, x1);
      chk({nm, "_c2_lit"}, c2, x2);
    end
  endtask

  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_ops(0, 0, 0, 0, 0, 0, 3'd0);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c1", c1, 32'd0);
    chk("rst_c2", c2, 32'd0);
    chk("rst_exc", 32'(exceptions), 32'd0);
    #20; @(posedge clk); #2; rst_n = 1'b1;

    // Single op, latency 4 from accept edge.
    send(F1, F2, F3, F4, F5, F6, 3'd0);
    repeat (3) @(negedge clk);
    chk("latency_pre", 32'(out_valid), 32'd0);
    wait_done("single", 32'h41880000, 32'h421C0000);
    @(posedge clk); #2;

    // Backpressure: hold 10 cycles and offer a new op that must be ignored.
    out_ready = 1'b0;
    send(F1, F2, F3, F4, F5, F6, 3'd2);
    wait_done("bp", 32'h41880000, 32'h421C0000);
    @(posedge clk); #2;
    set_ops(F4, F4, F4, F4, F1, 32'h0, 3'd5);
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #2; in_valid = 1'b0;
    @(negedge clk);
    chk("bp_c1_hold", c1, 32'h41880000);
    chk("bp_c2_hold", c2, 32'h421C0000);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(in_ready), 32'd1);
    chk("bp_c1_after", c1, 32'h41880000);

    // Back-to-back operand sets.
    send(F1, F2, F3, F4, F5, F6, 3'd0);
    set_ops(F1, F2, F3, F4, F1, 32'h0, 3'd1);
    in_valid = 1'b1;
    wait_done("b2b0", 32'h41880000, 32'h421C0000);
    send(F1, F2, F3, F4, F1, 32'h0, 3'd1);
    wait_done("b2b1", 32'h3F800000, 32'h40400000);
    @(posedge clk); #2;

    // Reset in S_C1 (step 2).
    send(F1, F2, F3, F4, F5, F6, 3'd3);
    @(posedge clk); #2;
    chk("pre_reset_step", 32'(step), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_c1", c1, 32'd0);
    chk("midrst_c2", c2, 32'd0);
    chk("midrst_mul_a", mul_a, 32'd0);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    send(F1, F2, F3, F4, F5, F6, 3'd0);
    wait_done("post_rst", 32'h41880000, 32'h421C0000);
    @(posedge clk); #2;

    // Overflow, then a normal op clears exceptions.
    send(32'h7F7FFFFF, 32'h0, 32'h0, 32'h0, F2, 32'h0, 3'd0);
    wait_done("ovf", 32'h7F800000, 32'h0);
`ifdef MATMUL_SEQ_EXC_EN
    chk("ovf_exc_bit", 32'(exceptions[2]), 32'd1);
`else
    chk("ovf_exc_off", 32'(exceptions), 32'd0);
`endif
    @(posedge clk); #2;
    send(F1, F2, F3, F4, F5, F6, 3'd0);
    wait_done("clr", 32'h41880000, 32'h421C0000);
    chk("clr_exc", 32'(exceptions), 32'd0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
